fetch_stage: RTL and testbench

//   Instruction-fetch stage plus F/D pipeline latch of the 32-bit core. Holds the PC,

---
 rtl/fetch_stage.sv | 81 ++++++++
 tb/tb_fetch_stage.sv | 129 ++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch plus the F/D pipeline latch.
//
// Holds the fetch PC, drives the instruction-memory address from it, and on
// each advancing edge captures the combinationally-read instruction word
// together with PC+1 into the F/D latch. The latched opcode and ALU-op fields
// are exposed as plain slices for the control decoder.
//
// Ports
//   clock, reset   rising-edge clock, synchronous active-high reset
//   stall          hold PC and F/D latch
//   redirect       load redirect_pc into PC and flush F/D to a bubble
//   redirect_pc    redirect target
//   address_imem   low IMEM_AW bits of pc (combinational)
//   q_imem         instruction word for address_imem, same cycle
//   pc             current fetch PC
//   fd_pc          PC+1 of the instruction held in F/D
//   fd_insn        latched instruction (NOP_INSN when a bubble)
//   fd_valid       1 = real instruction, 0 = bubble
//   fd_opcode      fd_insn[31:27]
//   fd_aluop       fd_insn[6:2]
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 12,
  parameter logic [31:0] NOP_INSN = 32'h0000_0000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic [IMEM_AW-1:0] address_imem,
  input  logic [31:0]        q_imem,
  output logic [31:0]        pc,
  output logic [31:0]        fd_pc,
  output logic [31:0]        fd_insn,
  output logic               fd_valid,
  output logic [4:0]         fd_opcode,
  output logic [4:0]         fd_aluop
);

  logic [31:0] r_pc;
  logic [31:0] r_fd_pc;
  logic [31:0] r_fd_insn;
  logic        r_fd_valid;
  logic [31:0] w_pc_inc;

  // Word-addressed; the 32-bit add wraps naturally at 2^32.
  assign w_pc_inc = r_pc + 32'd1;

  // Priority: reset > redirect > stall > advance. A redirect flushes the
  // wrong-path word so exactly one bubble precedes the target instruction.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_fd_insn  <= NOP_INSN;
      r_fd_pc    <= 32'd0;
      r_fd_valid <= 1'b0;
    end else if (redirect) begin
      r_pc       <= redirect_pc;
      r_fd_insn  <= NOP_INSN;
      r_fd_pc    <= 32'd0;
      r_fd_valid <= 1'b0;
    end else if (!stall) begin
      r_pc       <= w_pc_inc;
      r_fd_insn  <= q_imem;
      r_fd_pc    <= w_pc_inc;
      r_fd_valid <= 1'b1;
    end
  end

  // Upper PC bits are dropped: the memory aliases across its address space.
  assign address_imem = r_pc[IMEM_AW-1:0];
  assign pc           = r_pc;
  assign fd_pc        = r_fd_pc;
  assign fd_insn      = r_fd_insn;
  assign fd_valid     = r_fd_valid;
  // A bubble decodes as an R-type add of $0, which writes nothing.
  assign fd_opcode    = r_fd_insn[31:27];
  assign fd_aluop     = r_fd_insn[6:2];

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam int IMEM_AW = 12;

  logic               clock = 1'b0;
  logic               reset, stall, redirect;
  logic [31:0]        redirect_pc;
  logic [IMEM_AW-1:0] address_imem;
  logic [31:0]        q_imem;
  logic [31:0]        pc, fd_pc, fd_insn;
  logic               fd_valid;
  logic [4:0]         fd_opcode, fd_aluop;

  fetch_stage #(.RESET_PC(32'h0), .IMEM_AW(IMEM_AW), .NOP_INSN(32'h0)) dut (
    .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .address_imem(address_imem), .q_imem(q_imem),
    .pc(pc), .fd_pc(fd_pc), .fd_insn(fd_insn), .fd_valid(fd_valid),
    .fd_opcode(fd_opcode), .fd_aluop(fd_aluop)
  );

  always #5 clock = ~clock;

  // Instruction memory: imem[i] = 0x1000_0000 + i, combinational read.
  assign q_imem = 32'h1000_0000 + {20'd0, address_imem};

  typedef struct {
    logic        rst, stl, rd;
    logic [31:0] rpc;
    logic [31:0] epc, einsn, efdpc;
    logic        ev;
    string       name;
  } vec_t;

  vec_t stim_q[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic rst, input logic stl, input logic rd,
                     input logic [31:0] rpc, input logic [31:0] epc,
                     input logic [31:0] einsn, input logic [31:0] efdpc,
                     input logic ev, input string name);
    vec_t v;
    v.rst = rst; v.stl = stl; v.rd = rd; v.rpc = rpc;
    v.epc = epc; v.einsn = einsn; v.efdpc = efdpc; v.ev = ev; v.name = name;
    stim_q.push_back(v);
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one expected state per clock edge.
  initial begin
    vec_t e;
    logic [IMEM_AW-1:0] ea;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        ea = e.epc[IMEM_AW-1:0];
        chk32({e.name, ".pc"},       pc,       e.epc);
        chk32({e.name, ".fd_insn"},  fd_insn,  e.einsn);
        chk32({e.name, ".fd_pc"},    fd_pc,    e.efdpc);
        chk32({e.name, ".fd_valid"}, {31'd0, fd_valid}, {31'd0, e.ev});
        chk32({e.name, ".addr"},     {20'd0, address_imem}, {20'd0, ea});
        chk32({e.name, ".opcode"},   {27'd0, fd_opcode}, {27'd0, e.einsn[31:27]});
        chk32({e.name, ".aluop"},    {27'd0, fd_aluop},  {27'd0, e.einsn[6:2]});
      end
    end
  end

  // Driver: apply one vector per cycle away from the active edge.
  initial begin
    int waited;
    // rst stl rd rpc | pc insn fd_pc valid
    add(1,0,0,0,            32'h0,  32'h0,         32'h0,  0, "reset0");
    add(1,0,0,0,            32'h0,  32'h0,         32'h0,  0, "reset1");
    add(0,0,0,0,            32'h1,  32'h1000_0000, 32'h1,  1, "adv1");
    add(0,0,0,0,            32'h2,  32'h1000_0001, 32'h2,  1, "adv2");
    add(0,0,0,0,            32'h3,  32'h1000_0002, 32'h3,  1, "adv3");
    add(0,0,0,0,            32'h4,  32'h1000_0003, 32'h4,  1, "adv4");
    add(0,0,0,0,            32'h5,  32'h1000_0004, 32'h5,  1, "adv5");
    add(0,1,0,0,            32'h5,  32'h1000_0004, 32'h5,  1, "stall1");
    add(0,1,0,0,            32'h5,  32'h1000_0004, 32'h5,  1, "stall2");
    add(0,1,0,0,            32'h5,  32'h1000_0004, 32'h5,  1, "stall3");
    add(0,0,0,0,            32'h6,  32'h1000_0005, 32'h6,  1, "release");
    add(0,0,0,0,            32'h7,  32'h1000_0006, 32'h7,  1, "adv7");
    add(0,0,1,32'h40,       32'h40, 32'h0,         32'h0,  0, "redir40");
    add(0,0,0,0,            32'h41, 32'h1000_0040, 32'h41, 1, "tgt40");
    add(0,1,1,32'h20,       32'h20, 32'h0,         32'h0,  0, "stlredir20");
    add(0,0,0,0,            32'h21, 32'h1000_0020, 32'h21, 1, "tgt20");
    add(0,0,1,32'hFFFF_FFFF,32'hFFFF_FFFF, 32'h0,  32'h0,  0, "redirmax");
    add(0,0,0,0,            32'h0,  32'h1000_0FFF, 32'h0,  1, "wrap");
    add(0,0,0,0,            32'h1,  32'h1000_0000, 32'h1,  1, "postwrap");
    add(0,0,0,0,            32'h2,  32'h1000_0001, 32'h2,  1, "adv_pre_rst");
    add(1,1,1,32'h80,       32'h0,  32'h0,         32'h0,  0, "rst_over_all");
    add(0,0,0,0,            32'h1,  32'h1000_0000, 32'h1,  1, "after_rst");

    foreach (stim_q[i]) begin
      reset       = stim_q[i].rst;
      stall       = stim_q[i].stl;
      redirect    = stim_q[i].rd;
      redirect_pc = stim_q[i].rpc;
      exp_q.push_back(stim_q[i]);
      @(negedge clock);
    end
    reset = 1'b0; stall = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
